ifu_fetch: RTL and testbench

- Instruction fetch unit that sits directly upstream of the single-cycle execute core.
- Replaces the core's combinational instruction read with a handshaked fetch over a simple instruction-memory request/response bus.
- Holds the architectural PC and presents one instruction at a time to the core.
- Fetches the next instruction only after the core reports that instruction's next PC. There is no speculation and at most one memory request is outstanding.

---
 rtl/ifu_fetch.sv | 117 +++++++++++
 tb/tb_ifu_fetch.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - non-speculative instruction fetch unit, one request in flight
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    output logic        fetch_err,
    output logic [31:0] err_pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_EXEC,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        fetch_err_q, fetch_err_d;
    logic [31:0] err_pc_q, err_pc_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            inst_q      <= '0;
            inst_pc_q   <= '0;
            fetch_err_q <= 1'b0;
            err_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            inst_pc_q   <= inst_pc_d;
            fetch_err_q <= fetch_err_d;
            err_pc_q    <= err_pc_d;
        end
    end

    // Memory responses and core updates are only honoured in the one state
    // that expects them; anything else is treated as noise.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        inst_pc_d   = inst_pc_q;
        fetch_err_d = fetch_err_q;
        err_pc_d    = err_pc_q;

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (imem_rsp_err) begin
                        fetch_err_d = 1'b1;
                        err_pc_d    = pc_q;
                        state_d     = S_HALT;
                    end else begin
                        inst_d    = imem_rsp_data;
                        inst_pc_d = pc_q;
                        state_d   = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (inst_ready) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (upd_valid) begin
                    if (upd_pc[1:0] != 2'b00) begin
                        fetch_err_d = 1'b1;
                        err_pc_d    = upd_pc;
                        state_d     = S_HALT;
                    end else begin
                        pc_d    = upd_pc;
                        state_d = S_REQ;
                    end
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = pc_q;
    assign inst_valid     = (state_q == S_HOLD);
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign fetch_err      = fetch_err_q;
    assign err_pc         = err_pc_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - scenario bench for ifu_fetch with an expected-instruction queue
module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        imem_rsp_err = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        fetch_err;
    logic [31:0] err_pc;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   cycles = 0;
    int   accepts = 0;

    ifu_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .imem_rsp_err  (imem_rsp_err),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .fetch_err     (fetch_err),
        .err_pc        (err_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycles <= cycles + 1;
        if (!reset && imem_req_valid && imem_req_ready) accepts <= accepts + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic send_upd(input logic [31:0] pc);
        upd_valid = 1'b1;
        upd_pc    = pc;
        tick();
        upd_valid = 1'b0;
        upd_pc    = '0;
    endtask

    task automatic accept_inst();
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
    endtask

    // Plays the memory side of one fetch; the expected instruction is queued
    // from the bench's own pc model, not from the observed address.
    task automatic serve_request(input logic [31:0] exp_pc, input logic [31:0] data,
                                 input bit err, input int stall, input int delay,
                                 input bit drop_rsp, output logic [31:0] addr_seen,
                                 output bit addr_ok, output bit quiet_in_wait,
                                 output bit timed_out);
        int n = 0;
        timed_out     = 1'b0;
        addr_ok       = 1'b1;
        quiet_in_wait = 1'b1;
        addr_seen     = '0;
        while (!imem_req_valid && n < 20) begin
            tick();
            n++;
        end
        if (!imem_req_valid) begin
            timed_out = 1'b1;
            return;
        end
        addr_seen = imem_req_addr;
        repeat (stall) begin
            tick();
            if (!imem_req_valid || imem_req_addr !== addr_seen) addr_ok = 1'b0;
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        if (drop_rsp) return;
        repeat (delay) begin
            if (imem_req_valid) quiet_in_wait = 1'b0;
            tick();
        end
        if (imem_req_valid) quiet_in_wait = 1'b0;
        if (!err) sb_q.push_back({exp_pc, data});
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        imem_rsp_err   = err;
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({imem_req_valid, inst_valid, fetch_err} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_valids: got req/inst/err=%b%b%b want 000", imem_req_valid, inst_valid, fetch_err);
        end
        tests_run++;
        if ({inst, inst_pc, err_pc} !== 96'h0) begin
            tests_failed++;
            $display("FAIL reset_regs: got inst=%h inst_pc=%h err_pc=%h want all 0", inst, inst_pc, err_pc);
        end
        reset = 1'b0;
        tick();
        tests_run++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, RESET_PC}) begin
            tests_failed++;
            $display("FAIL reset_first_req: got valid=%b addr=%h want 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
        end
    endtask

    task automatic test_first_fetch();
        logic [31:0] a;
        bit ok, quiet, to;
        exp_t e;
        serve_request(RESET_PC, 32'h0000_0413, 1'b0, 0, 0, 1'b0, a, ok, quiet, to);
        tests_run++;
        if ({to, a} !== {1'b0, RESET_PC}) begin
            tests_failed++;
            $display("FAIL first_addr: got timeout=%b addr=%h want 0 %h", to, a, RESET_PC);
        end
        tests_run++;
        if (sb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL first_inst: scoreboard empty, inst_valid=%b", inst_valid);
        end else begin
            e = sb_q.pop_front();
            if ({inst_valid, inst, inst_pc} !== {1'b1, e.data, e.pc}) begin
                tests_failed++;
                $display("FAIL first_inst: got v=%b inst=%h pc=%h want 1 %h %h", inst_valid, inst, inst_pc, e.data, e.pc);
            end
        end
    endtask

    task automatic test_backpressure();
        bit stable = 1'b1;
        bit quiet = 1'b1;
        int acc0 = accepts;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                upd_valid = 1'b1;
                upd_pc    = 32'h8000_0200;
            end
            tick();
            upd_valid = 1'b0;
            if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h0000_0413, RESET_PC}) stable = 1'b0;
            if (imem_req_valid !== 1'b0) quiet = 1'b0;
        end
        tests_run++;
        if (stable !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_stable: got inst=%h pc=%h v=%b want 00000413 %h 1", inst, inst_pc, inst_valid, RESET_PC);
        end
        tests_run++;
        if ({quiet, accepts - acc0} !== {1'b1, 32'd0}) begin
            tests_failed++;
            $display("FAIL bp_no_req: got quiet=%b accepts=%0d want 1 0", quiet, accepts - acc0);
        end
        inst_ready = 1'b1;
        upd_valid  = 1'b1;
        upd_pc     = 32'h8000_0300;
        tick();
        inst_ready = 1'b0;
        upd_valid  = 1'b0;
        tests_run++;
        if (inst_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_drop_valid: got inst_valid=%b want 0", inst_valid);
        end
        quiet = 1'b1;
        repeat (3) begin
            tick();
            if (imem_req_valid !== 1'b0) quiet = 1'b0;
        end
        tests_run++;
        if (quiet !== 1'b1) begin
            tests_failed++;
            $display("FAIL exec_wait_upd: got a request before upd_valid, addr=%h want none", imem_req_addr);
        end
    endtask

    task automatic test_redirect();
        logic [31:0] a;
        bit ok, quiet, to;
        exp_t e;
        int c0 = cycles;
        send_upd(32'h8000_0100);
        serve_request(32'h8000_0100, 32'hAABB_CC01, 1'b0, 0, 0, 1'b0, a, ok, quiet, to);
        tests_run++;
        if (a !== 32'h8000_0100) begin
            tests_failed++;
            $display("FAIL redirect_addr: got %h want 80000100", a);
        end
        tests_run++;
        if ({inst_valid, cycles - c0} !== {1'b1, 32'd3}) begin
            tests_failed++;
            $display("FAIL redirect_latency: got v=%b cycles=%0d want 1 3", inst_valid, cycles - c0);
        end
        tests_run++;
        if (sb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL redirect_inst: scoreboard empty, inst_valid=%b", inst_valid);
        end else begin
            e = sb_q.pop_front();
            if ({inst_valid, inst, inst_pc} !== {1'b1, e.data, e.pc}) begin
                tests_failed++;
                $display("FAIL redirect_inst: got v=%b inst=%h pc=%h want 1 %h %h", inst_valid, inst, inst_pc, e.data, e.pc);
            end
        end
        accept_inst();
    endtask

    task automatic test_mem_stall();
        logic [31:0] a;
        bit ok, quiet, to;
        exp_t e;
        int acc0;
        send_upd(32'h8000_0104);
        acc0 = accepts;
        serve_request(32'h8000_0104, 32'h00A0_0093, 1'b0, 3, 4, 1'b0, a, ok, quiet, to);
        tests_run++;
        if ({ok, a} !== {1'b1, 32'h8000_0104}) begin
            tests_failed++;
            $display("FAIL stall_addr: got stable=%b addr=%h want 1 80000104", ok, a);
        end
        tests_run++;
        if ({quiet, accepts - acc0} !== {1'b1, 32'd1}) begin
            tests_failed++;
            $display("FAIL stall_one_req: got quiet=%b accepts=%0d want 1 1", quiet, accepts - acc0);
        end
        tests_run++;
        if (sb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL stall_inst: scoreboard empty, inst_valid=%b", inst_valid);
        end else begin
            e = sb_q.pop_front();
            if ({inst_valid, inst, inst_pc} !== {1'b1, e.data, e.pc}) begin
                tests_failed++;
                $display("FAIL stall_inst: got v=%b inst=%h pc=%h want 1 %h %h", inst_valid, inst, inst_pc, e.data, e.pc);
            end
        end
        accept_inst();
    endtask

    task automatic test_rsp_fault();
        logic [31:0] a;
        bit ok, quiet, to;
        int acc0;
        send_upd(32'h8000_0008);
        serve_request(32'h8000_0008, 32'h0, 1'b1, 0, 0, 1'b0, a, ok, quiet, to);
        tests_run++;
        if ({fetch_err, err_pc, inst_valid} !== {1'b1, 32'h8000_0008, 1'b0}) begin
            tests_failed++;
            $display("FAIL rsp_fault: got err=%b err_pc=%h v=%b want 1 80000008 0", fetch_err, err_pc, inst_valid);
        end
        acc0 = accepts;
        quiet = 1'b1;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            upd_valid = (i == 3);
            upd_pc    = 32'h8000_0010;
            tick();
            if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) quiet = 1'b0;
        end
        upd_valid      = 1'b0;
        imem_req_ready = 1'b0;
        tests_run++;
        if ({quiet, fetch_err, accepts - acc0} !== {2'b11, 32'd0}) begin
            tests_failed++;
            $display("FAIL halt_quiet: got quiet=%b err=%b accepts=%0d want 1 1 0", quiet, fetch_err, accepts - acc0);
        end
    endtask

    task automatic test_upd_misaligned();
        logic [31:0] a;
        bit ok, quiet, to;
        exp_t e;
        do_reset();
        serve_request(RESET_PC, 32'h0000_0013, 1'b0, 0, 1, 1'b0, a, ok, quiet, to);
        tests_run++;
        if (sb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL misalign_inst: scoreboard empty, inst_valid=%b", inst_valid);
        end else begin
            e = sb_q.pop_front();
            if ({inst_valid, inst, inst_pc} !== {1'b1, e.data, e.pc}) begin
                tests_failed++;
                $display("FAIL misalign_inst: got v=%b inst=%h pc=%h want 1 %h %h", inst_valid, inst, inst_pc, e.data, e.pc);
            end
        end
        accept_inst();
        send_upd(32'h8000_0102);
        quiet = 1'b1;
        repeat (5) begin
            tick();
            if (imem_req_valid !== 1'b0) quiet = 1'b0;
        end
        tests_run++;
        if ({quiet, fetch_err, err_pc} !== {2'b11, 32'h8000_0102}) begin
            tests_failed++;
            $display("FAIL misalign_fault: got quiet=%b err=%b err_pc=%h want 1 1 80000102", quiet, fetch_err, err_pc);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] a;
        bit ok, quiet, to;
        exp_t e;
        do_reset();
        serve_request(RESET_PC, 32'h1111_1111, 1'b0, 0, 0, 1'b1, a, ok, quiet, to);
        reset = 1'b1;
        tick();
        reset          = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        tests_run++;
        if ({inst_valid, fetch_err, imem_req_valid, imem_req_addr} !== {3'b001, RESET_PC}) begin
            tests_failed++;
            $display("FAIL late_rsp: got v=%b err=%b req=%b addr=%h want 0 0 1 %h", inst_valid, fetch_err, imem_req_valid, imem_req_addr, RESET_PC);
        end
        serve_request(RESET_PC, 32'h0010_0073, 1'b0, 0, 2, 1'b0, a, ok, quiet, to);
        tests_run++;
        if (sb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL restart_inst: scoreboard empty, inst_valid=%b", inst_valid);
        end else begin
            e = sb_q.pop_front();
            if ({inst_valid, inst, inst_pc} !== {1'b1, e.data, e.pc}) begin
                tests_failed++;
                $display("FAIL restart_inst: got v=%b inst=%h pc=%h want 1 %h %h", inst_valid, inst, inst_pc, e.data, e.pc);
            end
        end
        accept_inst();
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs [3];
        logic [31:0] a, d;
        bit ok, quiet, to;
        exp_t e;
        pcs[0] = 32'h0000_1000;
        pcs[1] = 32'hFFFF_FFFC;
        pcs[2] = 32'h0000_0000;
        for (int i = 0; i < 3; i++) begin
            d = $urandom;
            send_upd(pcs[i]);
            serve_request(pcs[i], d, 1'b0, i, i, 1'b0, a, ok, quiet, to);
            tests_run++;
            if (a !== pcs[i]) begin
                tests_failed++;
                $display("FAIL b2b_addr[%0d]: got %h want %h", i, a, pcs[i]);
            end
            tests_run++;
            if (sb_q.size() == 0) begin
                tests_failed++;
                $display("FAIL b2b_inst[%0d]: scoreboard empty, inst_valid=%b", i, inst_valid);
            end else begin
                e = sb_q.pop_front();
                if ({inst_valid, inst, inst_pc} !== {1'b1, e.data, e.pc}) begin
                    tests_failed++;
                    $display("FAIL b2b_inst[%0d]: got v=%b inst=%h pc=%h want 1 %h %h", i, inst_valid, inst, inst_pc, e.data, e.pc);
                end
            end
            accept_inst();
        end
        tests_run++;
        if (sb_q.size() != 0 || fetch_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_drain: got leftover=%0d err=%b want 0 0", sb_q.size(), fetch_err);
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_redirect();
        test_mem_stall();
        test_rsp_fault();
        test_upd_misaligned();
        test_reset_mid_wait();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
